fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction prefetch buffer between a variable-latency instruction memory and the IF/ID register.
- Fetches sequential words ahead of the decoder into a small FIFO of {pc, pc+4, instr} entries.
- Absorbs memory wait states and decode stalls.
- Flushes and refetches from a new address on branch/jump redirect from the ID stage.

Parameters:
- DEPTH, 4, number of FIFO entries (power of two, 2..16).
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clock  in  1  CPU clock; all state updates on rising edge.
- reset_0  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  word address of the request; stable while imem_req is high.
- imem_ack  in  1  memory completes the request this cycle; imem_data is valid.
- imem_data  in  32  instruction word returned with imem_ack.
- redirect  in  1  ID-stage branch/jump taken; flush and refetch.
- redirect_pc  in  32  new fetch address, sampled when redirect=1.
- stall  in  1  IF/ID hold (load-use stall); head entry is not consumed.
- valid_out  out  1  head entry is valid.
- pc_out  out  32  PC of the head instruction.
- pc4_out  out  32  pc_out + 4.
- instr_out  out  32  head instruction word.
- fill_count  out  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (asynchronous) sets:
  - fpc = RESET_PC
  - count = 0, read and write pointers = 0
  - state = FETCH
  - imem_req = 1, imem_addr = RESET_PC
  - valid_out = 0, fill_count = 0
  - pc_out, pc4_out, instr_out = 0
- Request rule: once imem_req rises, it and imem_addr hold until the cycle imem_ack=1. The memory never sees a withdrawn request.
- States:
  - IDLE: imem_req=0. Go to FETCH when count < DEPTH at the end of the cycle (after this cycle's pop).
  - FETCH: imem_req=1, imem_addr=fpc.
    - On imem_ack without redirect: push {fpc, fpc+4, imem_data}; fpc += 4.
    - Next state is FETCH if count after push/pop < DEPTH, otherwise IDLE.
  - DROP: imem_req=1, imem_addr = the stale address. It is entered only by a redirect during FETCH without ack.
    - On imem_ack: discard data, go to FETCH at the already-updated fpc.
- Pop: occurs when valid_out=1 and stall=0. The head advances at the edge. The new head is visible the next cycle (registered outputs; zero-latency head, no bubble when the queue is non-empty).
- Push and pop in the same cycle leave count unchanged.
- Latency: an empty queue with a 1-cycle memory gives valid_out 1 cycle after the ack edge (the ack edge writes the entry; valid_out is high in the next cycle).
- redirect=1 (highest priority, any state):
  - count, pointers cleared; valid_out=0 next cycle.
  - That cycle's pop and push are suppressed.
  - fpc = redirect_pc.
  - State transitions:
    - FETCH with ack: FETCH; the ack data is dropped.
    - FETCH without ack: DROP.
    - DROP: stays in DROP, or goes to FETCH if ack arrives that cycle.
    - IDLE: FETCH.
- Redirect takes precedence over stall.
- Wrap-around: the read and write pointers wrap modulo DEPTH. fpc wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- Push while count==DEPTH is unreachable by construction. It is covered by an assertion.
- imem_ack in IDLE is a protocol error. It is ignored and covered by an assertion.
- Reset asserted mid-request clears all state immediately. The memory model must also abandon its request on reset_0.

Decomposition:
- Shared package (pipeline_defs): PC_WIDTH=32, INSTR_WIDTH=32, the fetch-state encoding (IDLE=2'd0, FETCH=2'd1, DROP=2'd2), and the fetch entry struct {pc, pc4, instr}.
- One sub-module, fetch_fifo: DEPTH-entry register-array FIFO with push, pop, flush, count, and the head read port.
- fetch_queue holds the FSM, fpc, and the flush/priority logic.

Test Plan:
- Cold start, memory acks every cycle, stall=0 → addresses 0x0, 0x4, 0x8… issued back-to-back; valid_out from cycle 2; pc_out/pc4_out/instr_out stream 0x0/0x4/I0, 0x4/0x8/I1, …
- stall=1 held for 8 cycles with 1-cycle memory → fill_count reaches 4; imem_req drops to 0 (IDLE); head stays pc 0x0. Release stall → req reasserts the next cycle; order preserved; no entry lost or duplicated.
- Memory latency 3, redirect to 0x100 in the 2nd wait cycle of a fetch at 0x8 → imem_addr stays 0x8 until ack (DROP); data discarded; next request is 0x100; first valid head is pc 0x100.
- Redirect to 0x200 in the same cycle as an ack, with 3 entries queued and stall=0 → no pop occurs; the acked word is dropped; fill_count=0 next cycle; next imem_addr is 0x200.
- fpc at 0xFFFF_FFF8, sequential fetch → addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; pc4_out of the 0xFFFF_FFFC entry is 0x0.
- Assert reset_0 asynchronously mid-wait with 2 entries queued → valid_out=0 and fill_count=0 without a clock edge; after release, imem_addr=RESET_PC and imem_req=1.

Source files
------------

// File: rtl/pipeline_defs_pkg.sv
// ----------------------------------------------------------------------------
// pipeline_defs
//   Shared definitions for the instruction fetch front end: datapath widths,
//   fetch-state encoding, and the {pc, pc4, instr} entry carried from the
//   prefetch queue to the IF/ID register.
// ----------------------------------------------------------------------------
package pipeline_defs;

    localparam int unsigned PC_WIDTH    = 32;
    localparam int unsigned INSTR_WIDTH = 32;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // queue full, no request outstanding
        FETCH = 2'd1,   // request to fpc outstanding
        DROP  = 2'd2    // stale request outstanding after a redirect
    } fetch_state_e;

    // One prefetched instruction
    typedef struct packed {
        logic [PC_WIDTH-1:0]    pc;
        logic [PC_WIDTH-1:0]    pc4;
        logic [INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

    // Sequential successor of a word address; wraps modulo 2^PC_WIDTH
    function automatic logic [PC_WIDTH-1:0] pc_plus4(input logic [PC_WIDTH-1:0] pc);
        return pc + PC_WIDTH'(4);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
//   DEPTH-entry register-array FIFO of fetch entries with a registered head
//   read port. The head registers are loaded with the entry that will be at
//   the front after this edge, so a pop shows the next entry in the following
//   cycle without a bubble.
//
//   Ports
//     clock, reset_0 : clock, asynchronous active-high reset
//     push/push_entry: write one entry at the tail
//     pop            : consume the head (ignored when empty)
//     flush          : discard all entries; overrides push and pop
//     valid          : head entry is valid
//     head           : current head entry
//     count          : number of occupied entries
// ----------------------------------------------------------------------------
module fetch_fifo
    import pipeline_defs::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset_0,
    input  logic                   push,
    input  fetch_entry_t           push_entry,
    input  logic                   pop,
    input  logic                   flush,
    output logic                   valid,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned      PTR_W = $clog2(DEPTH);
    localparam int unsigned      CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_next;
    logic [CNT_W-1:0] count_next;
    logic             do_push;
    logic             do_pop;
    fetch_entry_t     head_next;

    // Effective operations and the head/occupancy after this edge
    always_comb begin
        do_push    = push && !flush;
        do_pop     = pop && valid && !flush;
        rd_next    = rd_ptr + PTR_W'(do_pop);
        count_next = count + CNT_W'(do_push) - CNT_W'(do_pop);
        // The entry being written becomes the head only when the queue would
        // otherwise be empty; in that case it bypasses the array.
        if (do_push && (wr_ptr == rd_next)) begin
            head_next = push_entry;
        end else begin
            head_next = mem[rd_next];
        end
    end

    // Storage array; contents are qualified by count, so no reset needed
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointers, occupancy and registered head port
    always_ff @(posedge clock or posedge reset_0) begin
        if (reset_0) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            head   <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
        end else begin
            rd_ptr <= rd_next;
            wr_ptr <= wr_ptr + PTR_W'(do_push);
            count  <= count_next;
            valid  <= (count_next != '0);
            head   <= head_next;
        end
    end

    // The sequencer never requests a word it has no room for
    a_no_push_when_full: assert property (
        @(posedge clock) disable iff (reset_0) !(do_push && (count == FULL))
    );

endmodule

// File: rtl/fetch_queue.sv
// ----------------------------------------------------------------------------
// fetch_queue
//   Instruction prefetch buffer between a variable-latency instruction memory
//   and the IF/ID register. Fetches sequential words into a small FIFO,
//   absorbs memory wait states and decode stalls, and flushes/refetches on a
//   redirect from ID.
//
//   Ports
//     clock, reset_0            : clock, asynchronous active-high reset
//     imem_req, imem_addr       : fetch request; held until imem_ack
//     imem_ack, imem_data       : memory completion and returned word
//     redirect, redirect_pc     : branch/jump taken in ID; new fetch address
//     stall                     : IF/ID hold, head is not consumed
//     valid_out                 : head entry valid
//     pc_out, pc4_out, instr_out: head entry fields
//     fill_count                : occupied entries
// ----------------------------------------------------------------------------
module fetch_queue
    import pipeline_defs::*;
#(
    parameter int unsigned         DEPTH    = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clock,
    input  logic                   reset_0,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    input  logic                   redirect,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    input  logic                   stall,
    output logic                   valid_out,
    output logic [PC_WIDTH-1:0]    pc_out,
    output logic [PC_WIDTH-1:0]    pc4_out,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic [$clog2(DEPTH):0] fill_count
);

    localparam int unsigned      CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

    fetch_state_e        state;
    fetch_state_e        state_next;
    logic [PC_WIDTH-1:0] fpc;
    logic [PC_WIDTH-1:0] fpc_next;
    logic [PC_WIDTH-1:0] addr_next;
    logic                req_next;
    logic                push;
    logic                pop;
    logic [CNT_W-1:0]    count_after;
    logic                has_room;
    fetch_entry_t        push_entry;
    fetch_entry_t        head;

    // Queue operations this cycle; a redirect suppresses both
    always_comb begin
        pop         = valid_out && !stall && !redirect;
        push        = (state == FETCH) && imem_ack && !redirect;
        count_after = fill_count + CNT_W'(push) - CNT_W'(pop);
        has_room    = (count_after < FULL);
        push_entry  = '{pc: fpc, pc4: pc_plus4(fpc), instr: imem_data};
    end

    // Next-state, next fetch address and next request
    always_comb begin
        state_next = state;
        fpc_next   = fpc;
        req_next   = 1'b0;
        addr_next  = imem_addr;

        if (redirect) begin
            fpc_next = redirect_pc;
        end else if (push) begin
            fpc_next = pc_plus4(fpc);
        end

        case (state)
            IDLE: begin
                // An ack here is a protocol error and is ignored
                if (redirect || has_room) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (redirect) begin
                    // Without ack the request cannot be withdrawn: wait it out
                    state_next = imem_ack ? FETCH : DROP;
                end else if (imem_ack && !has_room) begin
                    state_next = IDLE;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase

        req_next = (state_next != IDLE);
        // DROP keeps presenting the stale address until its ack
        if (state_next == FETCH) begin
            addr_next = fpc_next;
        end
    end

    // Sequencer state and registered request port
    always_ff @(posedge clock or posedge reset_0) begin
        if (reset_0) begin
            state     <= FETCH;
            fpc       <= RESET_PC;
            imem_req  <= 1'b1;
            imem_addr <= RESET_PC;
        end else begin
            state     <= state_next;
            fpc       <= fpc_next;
            imem_req  <= req_next;
            imem_addr <= addr_next;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset_0    (reset_0),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect),
        .valid      (valid_out),
        .head       (head),
        .count      (fill_count)
    );

    assign pc_out    = head.pc;
    assign pc4_out   = head.pc4;
    assign instr_out = head.instr;

    // Memory must not complete a request that was never issued
    a_no_ack_in_idle: assert property (
        @(posedge clock) disable iff (reset_0) !((state == IDLE) && imem_ack)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// ----------------------------------------------------------------------------
// tb_fetch_queue
//   Self-checking bench for fetch_queue: a fixed-latency memory model feeds
//   the DUT; every acked word at the expected sequential address is pushed to
//   a scoreboard and popped/compared when the DUT's head is consumed.
// ----------------------------------------------------------------------------
module tb_fetch_queue;
    import pipeline_defs::*;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clock;
    logic        reset_0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        valid_out;
    logic [31:0] pc_out;
    logic [31:0] pc4_out;
    logic [31:0] instr_out;
    logic [2:0]  fill_count;

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clock       (clock),
        .reset_0     (reset_0),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .valid_out   (valid_out),
        .pc_out      (pc_out),
        .pc4_out     (pc4_out),
        .instr_out   (instr_out),
        .fill_count  (fill_count)
    );

    int           n_checks = 0;
    int           n_errors = 0;
    fetch_entry_t sb[$];
    logic [31:0]  exp_fpc;
    logic [31:0]  mem_addr;
    logic         mem_busy;
    int           mem_wait;
    int           mem_lat;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    // One clock: memory model and scoreboard act at the falling edge,
    // returns 1ns after the rising edge.
    task automatic cycle();
        fetch_entry_t e;
        logic         ack;
        @(negedge clock);
        ack = 1'b0;
        if (imem_req) begin
            if (mem_busy) begin
                check("req_addr_hold", imem_addr, mem_addr);
            end else begin
                mem_busy = 1'b1;
                mem_addr = imem_addr;
                mem_wait = 0;
            end
            mem_wait++;
            if (mem_wait >= mem_lat) begin
                ack      = 1'b1;
                mem_busy = 1'b0;
            end
        end else if (mem_busy) begin
            check("req_withdrawn", 32'(imem_req), 32'd1);
            mem_busy = 1'b0;
        end
        imem_ack  = ack;
        imem_data = instr_of(mem_addr);

        if (redirect) begin
            sb.delete();
            exp_fpc = redirect_pc;
        end else begin
            if (valid_out && !stall) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_head", 32'(valid_out), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("head_pc", pc_out, e.pc);
                    check("head_pc4", pc4_out, e.pc4);
                    check("head_instr", instr_out, e.instr);
                end
            end
            if (ack && (mem_addr == exp_fpc)) begin
                e.pc    = exp_fpc;
                e.pc4   = exp_fpc + 32'd4;
                e.instr = instr_of(exp_fpc);
                sb.push_back(e);
                exp_fpc = exp_fpc + 32'd4;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_0  = 1'b1;
        redirect = 1'b0;
        stall    = 1'b0;
        imem_ack = 1'b0;
        mem_busy = 1'b0;
        mem_wait = 0;
        sb.delete();
        exp_fpc  = RESET_PC;
        repeat (2) @(posedge clock);
        #1;
        reset_0 = 1'b0;
    endtask

    initial begin
        int n;
        reset_0     = 1'b0;
        imem_ack    = 1'b0;
        imem_data   = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        stall       = 1'b0;
        mem_lat     = 1;
        mem_busy    = 1'b0;
        mem_wait    = 0;
        mem_addr    = '0;
        exp_fpc     = RESET_PC;

        // Reset values, observed before any clock edge
        #1 reset_0 = 1'b1;
        #1;
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_fill", 32'(fill_count), 32'd0);
        check("rst_req", 32'(imem_req), 32'd1);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_pc", pc_out, 32'd0);
        check("rst_pc4", pc4_out, 32'd0);
        check("rst_instr", instr_out, 32'd0);

        // Cold start, 1-cycle memory, no stall
        mem_lat = 1;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            cycle();
            check("cold_addr", imem_addr, 32'(4 * (k + 1)));
            if (k == 0) check("cold_valid_latency", 32'(valid_out), 32'd1);
        end
        repeat (12) cycle();

        // Decode stall fills the queue, sequencer idles, then resumes
        mem_lat = 1;
        do_reset();
        stall = 1'b1;
        repeat (8) cycle();
        check("stall_fill", 32'(fill_count), 32'd4);
        check("stall_req_idle", 32'(imem_req), 32'd0);
        check("stall_head_pc", pc_out, 32'h0);
        check("stall_valid", 32'(valid_out), 32'd1);
        stall = 1'b0;
        cycle();
        check("resume_req", 32'(imem_req), 32'd1);
        check("resume_addr", imem_addr, 32'h10);
        repeat (12) cycle();

        // Redirect during a wait state: stale request completes, data dropped
        mem_lat = 3;
        do_reset();
        n = 0;
        while (!(mem_busy && (mem_addr == 32'h8) && (mem_wait == 1)) && (n < 60)) begin
            cycle();
            n++;
        end
        check("drop_setup_reached", 32'(mem_busy && (mem_addr == 32'h8) && (mem_wait == 1)), 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        cycle();
        redirect = 1'b0;
        check("drop_addr_held", imem_addr, 32'h8);
        check("drop_req_held", 32'(imem_req), 32'd1);
        check("drop_valid", 32'(valid_out), 32'd0);
        check("drop_fill", 32'(fill_count), 32'd0);
        cycle();
        check("drop_next_addr", imem_addr, 32'h100);
        n = 0;
        while (!valid_out && (n < 20)) begin
            cycle();
            n++;
        end
        check("drop_head_reached", 32'(valid_out), 32'd1);
        check("drop_first_pc", pc_out, 32'h100);
        repeat (10) cycle();

        // Redirect coinciding with an ack while three entries are queued
        mem_lat = 1;
        do_reset();
        stall = 1'b1;
        n = 0;
        while ((fill_count != 3'd3) && (n < 20)) begin
            cycle();
            n++;
        end
        check("redir_ack_setup_fill", 32'(fill_count), 32'd3);
        stall       = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        cycle();
        redirect = 1'b0;
        check("redir_ack_fill", 32'(fill_count), 32'd0);
        check("redir_ack_valid", 32'(valid_out), 32'd0);
        check("redir_ack_addr", imem_addr, 32'h200);
        check("redir_ack_req", 32'(imem_req), 32'd1);
        cycle();
        check("redir_ack_head_valid", 32'(valid_out), 32'd1);
        check("redir_ack_head_pc", pc_out, 32'h200);
        repeat (8) cycle();

        // Fetch address wraps at the top of the address space
        mem_lat = 1;
        do_reset();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        cycle();
        redirect = 1'b0;
        check("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
        cycle();
        check("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
        check("wrap_head0", pc_out, 32'hFFFF_FFF8);
        cycle();
        check("wrap_addr2", imem_addr, 32'h0);
        check("wrap_head1", pc_out, 32'hFFFF_FFFC);
        check("wrap_pc4", pc4_out, 32'h0);
        repeat (6) cycle();

        // Asynchronous reset mid-wait with two entries queued
        mem_lat = 3;
        do_reset();
        stall = 1'b1;
        n = 0;
        while (!((fill_count == 3'd2) && mem_busy) && (n < 30)) begin
            cycle();
            n++;
        end
        check("areset_setup", 32'((fill_count == 3'd2) && mem_busy), 32'd1);
        #2 reset_0 = 1'b1;
        #1;
        check("areset_valid", 32'(valid_out), 32'd0);
        check("areset_fill", 32'(fill_count), 32'd0);
        do_reset();
        check("areset_req", 32'(imem_req), 32'd1);
        check("areset_addr", imem_addr, RESET_PC);
        repeat (10) cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
